// File: rtl/async_fifo_w32_r16.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : async_fifo_w32_r16
// Description : Dual-clock FIFO, 2048x32 write side narrowed to a 4096x16
//               read stream (low half first), with water levels and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_w32_r16 #(
    parameter int WR_DEPTH_WIDTH   = 11,
    parameter int WR_DATA_WIDTH    = 32,
    parameter int RD_DEPTH_WIDTH   = 12,
    parameter int RD_DATA_WIDTH    = 16,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty
);

    localparam logic [WR_DEPTH_WIDTH:0] c_WR_DEPTH     = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    localparam logic [WR_DEPTH_WIDTH:0] c_ALMOST_FULL  = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
    localparam logic [RD_DEPTH_WIDTH:0] c_ALMOST_EMPTY = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

    function automatic logic [WR_DEPTH_WIDTH:0] gray2bin_wr(input logic [WR_DEPTH_WIDTH:0] g);
        logic [WR_DEPTH_WIDTH:0] b;
        b[WR_DEPTH_WIDTH] = g[WR_DEPTH_WIDTH];
        for (int i = WR_DEPTH_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [RD_DEPTH_WIDTH:0] gray2bin_rd(input logic [RD_DEPTH_WIDTH:0] g);
        logic [RD_DEPTH_WIDTH:0] b;
        b[RD_DEPTH_WIDTH] = g[RD_DEPTH_WIDTH];
        for (int i = RD_DEPTH_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [WR_DATA_WIDTH-1:0] r_mem [0:(1<<WR_DEPTH_WIDTH)-1];

    // ---------------- write domain ----------------
    logic [WR_DEPTH_WIDTH:0] r_wptr, r_wptr_gray, w_wptr_next, w_wr_level_next, w_rptr_words;
    logic [RD_DEPTH_WIDTH:0] r_rptr_gray_s1, r_rptr_gray_s2, w_rptr_sync_bin;
    logic                    r_wr_full, r_almost_full, w_wr_accept;
    logic [WR_DEPTH_WIDTH:0] r_wr_level;

    assign w_wr_accept     = wr_en & ~r_wr_full;
    assign w_wptr_next     = r_wptr + {{WR_DEPTH_WIDTH{1'b0}}, w_wr_accept};
    assign w_rptr_sync_bin = gray2bin_rd(r_rptr_gray_s2);
    // A word stays occupied until both of its halves have been read out.
    assign w_rptr_words    = w_rptr_sync_bin[RD_DEPTH_WIDTH:1];
    assign w_wr_level_next = w_wptr_next - w_rptr_words;

    always_ff @(posedge wr_clk) begin
        if (w_wr_accept) r_mem[r_wptr[WR_DEPTH_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_wptr         <= '0;
            r_wptr_gray    <= '0;
            r_rptr_gray_s1 <= '0;
            r_rptr_gray_s2 <= '0;
            r_wr_level     <= '0;
            r_wr_full      <= 1'b0;
            r_almost_full  <= 1'b0;
        end else begin
            r_wptr         <= w_wptr_next;
            r_wptr_gray    <= w_wptr_next ^ (w_wptr_next >> 1);
            r_rptr_gray_s1 <= r_rptr_gray;
            r_rptr_gray_s2 <= r_rptr_gray_s1;
            r_wr_level     <= w_wr_level_next;
            r_wr_full      <= (w_wr_level_next == c_WR_DEPTH);
            r_almost_full  <= (w_wr_level_next >= c_ALMOST_FULL);
        end
    end

    // ---------------- read domain ----------------
    logic [RD_DEPTH_WIDTH:0] r_rptr, r_rptr_gray, w_rptr_next, w_rd_level_next, w_wptr_halves;
    logic [WR_DEPTH_WIDTH:0] r_wptr_gray_s1, r_wptr_gray_s2, w_wptr_sync_bin;
    logic                    r_rd_empty, r_almost_empty, w_rd_accept;
    logic [RD_DEPTH_WIDTH:0] r_rd_level;
    logic [RD_DATA_WIDTH-1:0] r_rd_data;
    logic [WR_DATA_WIDTH-1:0] w_rd_word;

    assign w_rd_accept     = rd_en & ~r_rd_empty;
    assign w_rptr_next     = r_rptr + {{RD_DEPTH_WIDTH{1'b0}}, w_rd_accept};
    assign w_wptr_sync_bin = gray2bin_wr(r_wptr_gray_s2);
    assign w_wptr_halves   = {w_wptr_sync_bin, 1'b0};
    assign w_rd_level_next = w_wptr_halves - w_rptr_next;
    assign w_rd_word       = r_mem[r_rptr[RD_DEPTH_WIDTH-1:1]];

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_rptr         <= '0;
            r_rptr_gray    <= '0;
            r_wptr_gray_s1 <= '0;
            r_wptr_gray_s2 <= '0;
            r_rd_level     <= '0;
            r_rd_empty     <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_data      <= '0;
        end else begin
            r_rptr         <= w_rptr_next;
            r_rptr_gray    <= w_rptr_next ^ (w_rptr_next >> 1);
            r_wptr_gray_s1 <= r_wptr_gray;
            r_wptr_gray_s2 <= r_wptr_gray_s1;
            r_rd_level     <= w_rd_level_next;
            r_rd_empty     <= (w_rd_level_next == '0);
            r_almost_empty <= (w_rd_level_next <= c_ALMOST_EMPTY);
            // Little-endian split: even read pointer selects the low half.
            if (w_rd_accept)
                r_rd_data <= r_rptr[0] ? w_rd_word[WR_DATA_WIDTH-1:RD_DATA_WIDTH]
                                       : w_rd_word[RD_DATA_WIDTH-1:0];
        end
    end

    assign wr_full        = r_wr_full;
    assign wr_water_level = r_wr_level;
    assign almost_full    = r_almost_full;
    assign rd_data        = r_rd_data;
    assign rd_empty       = r_rd_empty;
    assign rd_water_level = r_rd_level;
    assign almost_empty   = r_almost_empty;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_w32_r16.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_w32_r16
// Description : Self-checking bench for async_fifo_w32_r16 against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_w32_r16;

    logic        clk = 1'b0;
    logic        rclk7 = 1'b0;
    logic        split = 1'b0;
    logic        tb_rst = 1'b1;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_full, almost_full, rd_empty, almost_empty;
    logic [11:0] wr_water_level;
    logic [12:0] rd_water_level;
    logic [15:0] rd_data;
    logic        rd_clk_w;

    int checks = 0;
    int failures = 0;
    logic [15:0] q[$];
    logic        wdone;

    always #5 clk = ~clk;
    always #3.5 rclk7 = ~rclk7;
    assign rd_clk_w = split ? rclk7 : clk;

    async_fifo_w32_r16 dut (
        .wr_clk(clk), .wr_rst(tb_rst), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(wr_full), .wr_water_level(wr_water_level), .almost_full(almost_full),
        .rd_clk(rd_clk_w), .rd_rst(tb_rst), .rd_en(rd_en), .rd_data(rd_data),
        .rd_empty(rd_empty), .rd_water_level(rd_water_level), .almost_empty(almost_empty)
    );

    task automatic do_reset(input logic sp);
        wr_en = 1'b0; rd_en = 1'b0; tb_rst = 1'b1; split = sp;
        q.delete();
        #200;
        @(negedge clk); tb_rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        checks += 7;
        if (rd_empty !== 1'b1) begin failures++; $display("FAIL reset_rd_empty got=%0b exp=1", rd_empty); end
        if (wr_full !== 1'b0) begin failures++; $display("FAIL reset_wr_full got=%0b exp=0", wr_full); end
        if (wr_water_level !== 12'd0) begin failures++; $display("FAIL reset_wr_level got=%0d exp=0", wr_water_level); end
        if (rd_water_level !== 13'd0) begin failures++; $display("FAIL reset_rd_level got=%0d exp=0", rd_water_level); end
        if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%0b exp=1", almost_empty); end
        if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%0b exp=0", almost_full); end
        if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
    endtask

    task automatic test_fill;
        int cnt = 0;
        logic [31:0] wd = 32'hFFFF_FFFF;
        do_reset(1'b0);
        for (int i = 0; i < 2049; i++) begin
            wr_en = 1'b1; wr_data = wd;
            if (cnt < 2048) begin
                cnt++; q.push_back(wd[15:0]); q.push_back(wd[31:16]);
            end
            wd = wd - 32'd1;
            @(negedge clk);
            checks += 3;
            if (wr_water_level !== 12'(cnt)) begin failures++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, wr_water_level, cnt); end
            if (wr_full !== (cnt == 2048)) begin failures++; $display("FAIL fill_full i=%0d got=%0b exp=%0b", i, wr_full, cnt == 2048); end
            if (almost_full !== (cnt >= 1020)) begin failures++; $display("FAIL fill_almost_full i=%0d got=%0b exp=%0b", i, almost_full, cnt >= 1020); end
        end
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        checks += 3;
        if (rd_water_level !== 13'd4096) begin failures++; $display("FAIL fill_rd_level got=%0d exp=4096", rd_water_level); end
        if (rd_empty !== 1'b0) begin failures++; $display("FAIL fill_rd_empty got=%0b exp=0", rd_empty); end
        if (almost_empty !== 1'b0) begin failures++; $display("FAIL fill_almost_empty got=%0b exp=0", almost_empty); end
    endtask

    task automatic test_drain;
        logic [15:0] exp, last = 16'h0;
        logic pend;
        for (int i = 0; i < 4097; i++) begin
            rd_en = 1'b1;
            pend = (q.size() > 0);
            if (pend) exp = q.pop_front();
            @(negedge clk);
            checks += 3;
            if (pend) begin
                if (rd_data !== exp) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, rd_data, exp); end
                last = exp;
            end else if (rd_data !== last) begin
                failures++; $display("FAIL drain_hold i=%0d got=%h exp=%h", i, rd_data, last);
            end
            if (rd_water_level !== 13'(q.size())) begin failures++; $display("FAIL drain_level i=%0d got=%0d exp=%0d", i, rd_water_level, q.size()); end
            if (rd_empty !== (q.size() == 0)) begin failures++; $display("FAIL drain_empty i=%0d got=%0b exp=%0b", i, rd_empty, q.size() == 0); end
        end
        rd_en = 1'b0;
        repeat (6) @(negedge clk);
        checks += 3;
        if (wr_water_level !== 12'd0) begin failures++; $display("FAIL drain_wr_level got=%0d exp=0", wr_water_level); end
        if (wr_full !== 1'b0) begin failures++; $display("FAIL drain_wr_full got=%0b exp=0", wr_full); end
        if (almost_full !== 1'b0) begin failures++; $display("FAIL drain_almost_full got=%0b exp=0", almost_full); end
    endtask

    task automatic test_latency;
        int n = 0;
        wr_en = 1'b1; wr_data = 32'h1234_5678;
        @(negedge clk);
        wr_en = 1'b0;
        while (rd_empty && n < 3) begin @(negedge clk); n++; end
        checks++;
        if (rd_empty !== 1'b0) begin failures++; $display("FAIL latency_empty_fall got=%0b exp=0 after %0d cycles", rd_empty, n); end
        rd_en = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_data !== 16'h5678) begin failures++; $display("FAIL latency_low got=%h exp=5678", rd_data); end
        @(negedge clk);
        rd_en = 1'b0;
        checks += 2;
        if (rd_data !== 16'h1234) begin failures++; $display("FAIL latency_high got=%h exp=1234", rd_data); end
        if (rd_empty !== 1'b1) begin failures++; $display("FAIL latency_empty_after got=%0b exp=1", rd_empty); end
    endtask

    task automatic test_almost_empty;
        logic [31:0] w;
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            w = $urandom; wr_en = 1'b1; wr_data = w;
            q.push_back(w[15:0]); q.push_back(w[31:16]);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        checks += 2;
        if (rd_water_level !== 13'd6) begin failures++; $display("FAIL ae_level6 got=%0d exp=6", rd_water_level); end
        if (almost_empty !== 1'b0) begin failures++; $display("FAIL ae_at6 got=%0b exp=0", almost_empty); end
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1; exp = q.pop_front();
            @(negedge clk);
            rd_en = 1'b0;
            checks += 3;
            if (rd_data !== exp) begin failures++; $display("FAIL ae_data i=%0d got=%h exp=%h", i, rd_data, exp); end
            if (rd_water_level !== 13'(q.size())) begin failures++; $display("FAIL ae_level i=%0d got=%0d exp=%0d", i, rd_water_level, q.size()); end
            if (almost_empty !== (q.size() <= 4)) begin failures++; $display("FAIL ae_flag level=%0d got=%0b exp=%0b", q.size(), almost_empty, q.size() <= 4); end
            if (i == 1) begin
                repeat (5) @(negedge clk);
                checks++;
                if (wr_water_level !== 12'd2) begin failures++; $display("FAIL ae_wr_level got=%0d exp=2", wr_water_level); end
            end
        end
    endtask

    task automatic test_concurrent;
        do_reset(1'b1);
        wdone = 1'b0;
        fork
            begin : writer
                logic [31:0] w;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if ((i % 2) == 0 && !wr_full) begin
                        w = $urandom; wr_en = 1'b1; wr_data = w;
                        q.push_back(w[15:0]); q.push_back(w[31:16]);
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge clk);
                wr_en = 1'b0;
                wdone = 1'b1;
            end
            begin : reader
                logic [15:0] exp, last;
                logic pend = 1'b0;
                int cyc = 0;
                @(negedge rd_clk_w);
                last = rd_data;
                while (!(wdone && q.size() == 0 && !pend) && cyc < 8000) begin
                    rd_en = 1'b1;
                    if (!rd_empty) begin
                        checks++;
                        if (q.size() == 0) begin
                            failures++; $display("FAIL conc_false_data rd_empty=%0b model_size=0", rd_empty);
                            pend = 1'b0;
                        end else begin
                            exp = q.pop_front(); pend = 1'b1;
                        end
                    end else begin
                        pend = 1'b0;
                    end
                    @(negedge rd_clk_w);
                    cyc++;
                    checks++;
                    if (pend && rd_data !== exp) begin failures++; $display("FAIL conc_data cyc=%0d got=%h exp=%h", cyc, rd_data, exp); end
                    if (!pend && rd_data !== last) begin failures++; $display("FAIL conc_hold cyc=%0d got=%h exp=%h", cyc, rd_data, last); end
                    last = rd_data;
                    if (pend && wdone && q.size() == 0) pend = 1'b0;
                end
                rd_en = 1'b0;
                checks++;
                if (cyc >= 8000) begin failures++; $display("FAIL conc_timeout remaining=%0d exp=0", q.size()); end
            end
        join
        repeat (8) @(negedge rd_clk_w);
        checks += 2;
        if (rd_empty !== 1'b1) begin failures++; $display("FAIL conc_end_empty got=%0b exp=1", rd_empty); end
        if (rd_water_level !== 13'd0) begin failures++; $display("FAIL conc_end_level got=%0d exp=0", rd_water_level); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_latency();
        test_almost_empty();
        test_concurrent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
